// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 12-bit LFSR stream
// (taps 0,3,5,11, shift-left, feedback into bit 0, serial bit = MSB).
// The checker hunts for sync, verifies the prediction for LOCK_CNT bits,
// then flywheels the sequence. While locked it reports per-bit errors,
// keeps a saturating error count and drops lock on a burst of errors.
// Optional build macro: PRBS_SEED_MARK_EN adds the seed_mark output
// (a pulse at each sequence-period boundary); without it seed_mark is 0.
module prbs_checker #(
  parameter int          N           = 12,
  parameter logic [11:0] SEED        = 12'hC0D,
  parameter int          LOCK_CNT    = 24,
  parameter int          WINDOW      = 64,
  parameter int          LOSS_THRESH = 8,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             seed_mark
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  // The tap positions are hard-wired for the 12-bit polynomial, and an
  // all-zero seed would be the LFSR lockup state.
  if (N != 12) begin : g_bad_n
    $error("prbs_checker: N must be 12 (fixed polynomial)");
  end
  if (SEED == 12'h000) begin : g_bad_seed
    $error("prbs_checker: SEED must be nonzero");
  end

  logic [1:0]         state;
  logic [N-1:0]       hist;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WERR_W-1:0]  win_err;

  logic              exp_bit;
  logic              bit_err;
  logic              hist_zero;
  logic [WERR_W-1:0] win_err_inc;
  logic              loss;
  logic [N-1:0]      hist_fly;

  // Saturating increment for the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Prediction of the next bit from the history, plus loss-of-lock test.
  always_comb begin
    exp_bit     = hist[0] ^ hist[3] ^ hist[5] ^ hist[N-1];
    bit_err     = bit_in ^ exp_bit;
    hist_zero   = (hist == '0);
    hist_fly    = {hist[N-2:0], exp_bit};
    // win_err never exceeds LOSS_THRESH-1 while locked, so this cannot wrap.
    win_err_inc = win_err + WERR_W'(1);
    loss        = bit_err && (win_err_inc >= WERR_W'(LOSS_THRESH));
  end

  // Sync state machine: HUNT fills history, VERIFY counts consecutive
  // correct predictions, LOCKED flywheels and watches the error window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HUNT;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_valid) begin
        case (state)
          ST_HUNT: begin
            hist <= {hist[N-2:0], bit_in};
            if (fill_cnt == FILL_W'(N - 1)) begin
              fill_cnt  <= '0;
              match_cnt <= '0;
              state     <= ST_VERIFY;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          ST_VERIFY: begin
            hist <= {hist[N-2:0], bit_in};
            // An all-zero history predicts zeros forever; never count it.
            if (!bit_err && !hist_zero) begin
              if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
                locked    <= 1'b1;
                state     <= ST_LOCKED;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Shift in the prediction so one line error is seen only once.
            hist      <= hist_fly;
            err_pulse <= bit_err;
            if (loss) begin
              fill_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
              locked   <= 1'b0;
              state    <= ST_HUNT;
            end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              win_err <= bit_err ? win_err_inc : win_err;
            end
          end
          default: begin
            state  <= ST_HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Error counter: clear has priority over a coincident error.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (bit_valid && (state == ST_LOCKED) && bit_err) begin
      err_count <= sat_inc(err_count);
    end
  end

`ifdef PRBS_SEED_MARK_EN
  // Period marker: pulse after a locked bit that brings history back to SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_mark <= 1'b0;
    end else begin
      seed_mark <= bit_valid && (state == ST_LOCKED) && (hist_fly == SEED);
    end
  end
`else
  // Period marker not built.
  assign seed_mark = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: the driver pushes the expected
// post-edge outputs for every cycle it drives; a negedge monitor pops and
// compares them. A -1 field means "not compared this cycle".
module tb_prbs_checker;

  localparam logic [11:0] SEED = 12'hC0D;
`ifdef PRBS_SEED_MARK_EN
  localparam int SM_EXP  = -1;
  localparam int N_CLEAN = 9000;
`else
  localparam int SM_EXP  = 0;
  localparam int N_CLEAN = 5000;
`endif

  logic        clk;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        seed_mark;

  prbs_checker dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .seed_mark (seed_mark)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    lk;
    int    ep;
    int    ec;
    int    sm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          tests_run = 0;
  int          fail_cnt  = 0;
  int          vcount    = 0;
  int          last_mark = 0;
  int          marks     = 0;
  bit          mark_en   = 1'b0;
  logic [11:0] g;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic exp_t ex(input string tag, input int lk, input int ep, input int ec, input int sm);
    exp_t e;
    e.tag = tag;
    e.lk  = lk;
    e.ep  = ep;
    e.ec  = ec;
    e.sm  = sm;
    return e;
  endfunction

  // Reference generator: emit MSB, then shift in the feedback bit.
  task automatic gen_bit(output logic b);
    b = g[11];
    g = {g[10:0], g[0] ^ g[3] ^ g[5] ^ g[11]};
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic c, input exp_t e);
    @(negedge clk);
    #1;
    reset     = r;
    bit_in    = b;
    bit_valid = v;
    clear_err = c;
    if (v && !r) vcount++;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.lk >= 0) check_val({mon_e.tag, ".locked"}, {31'b0, locked}, mon_e.lk);
      if (mon_e.ep >= 0) check_val({mon_e.tag, ".err_pulse"}, {31'b0, err_pulse}, mon_e.ep);
      if (mon_e.ec >= 0) check_val({mon_e.tag, ".err_count"}, {16'b0, err_count}, mon_e.ec);
      if (mon_e.sm >= 0) check_val({mon_e.tag, ".seed_mark"}, {31'b0, seed_mark}, mon_e.sm);
    end
  end

`ifdef PRBS_SEED_MARK_EN
  always @(negedge clk) begin
    if (mark_en && seed_mark) begin
      if (last_mark > 0) begin
        check_val("mark_gap", vcount - last_mark, 4095);
        marks++;
      end
      last_mark = vcount;
    end
  end
`endif

  initial begin
    logic b;
    int   cnt;
    clk       = 1'b0;
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_err = 1'b0;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, ex("reset", 0, 0, 0, 0));

    // Clean stream: lock exactly after the 36th valid bit, no errors
    g = SEED;
    mark_en = 1'b1;
    for (int k = 1; k <= N_CLEAN; k++) begin
      gen_bit(b);
      step(1'b0, b, 1'b1, 1'b0, ex("clean", (k >= 36) ? 1 : 0, 0, 0, SM_EXP));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("idle", 1, 0, 0, 0));
    mark_en = 1'b0;
`ifdef PRBS_SEED_MARK_EN
    check_val("marks_seen", {31'b0, (marks >= 1)}, 1);
`endif

    // Single inverted bit: one pulse, count 1, lock held
    gen_bit(b);
    step(1'b0, ~b, 1'b1, 1'b0, ex("invert", 1, 1, 1, SM_EXP));
    for (int k = 0; k < 100; k++) begin
      gen_bit(b);
      step(1'b0, b, 1'b1, 1'b0, ex("post_inv", 1, 0, 1, SM_EXP));
    end

    // clear_err on a cycle without a valid bit
    step(1'b0, 1'b0, 1'b0, 1'b1, ex("clr_idle", 1, 0, 0, 0));

    // Forced zeros for 64 bits: lock must be gone by the last one
    for (int k = 1; k <= 64; k++) begin
      gen_bit(b);
      step(1'b0, 1'b0, 1'b1, 1'b0, ex("zeros", (k == 64) ? 0 : -1, -1, -1, SM_EXP));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("lost", 0, 0, -1, 0));
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("lost2", 0, 0, -1, 0));
    check_val("err_ge_thresh", {31'b0, (err_count >= 16'd8)}, 1);

    // Resume clean stream: relock on the 36th valid bit
    for (int k = 1; k <= 36; k++) begin
      gen_bit(b);
      step(1'b0, b, 1'b1, 1'b0, ex("relock", (k == 36) ? 1 : -1, 0, -1, SM_EXP));
    end
    for (int k = 0; k < 10; k++) begin
      gen_bit(b);
      step(1'b0, b, 1'b1, 1'b0, ex("relocked", 1, 0, -1, SM_EXP));
    end

    // Reset in the middle of lock with a nonzero count
    step(1'b1, 1'b0, 1'b1, 1'b0, ex("rst_mid", 0, 0, 0, 0));

    // Stuck-at-0 input never locks and never counts
    for (int k = 0; k < 200; k++)
      step(1'b0, 1'b0, 1'b1, 1'b0, ex("stuck0", 0, 0, 0, 0));

    // Sparse valid strobes (every 3rd cycle) with garbage on idle cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, ex("reset2", 0, 0, 0, 0));
    g   = SEED;
    cnt = 0;
    for (int cyc = 0; cnt < 60; cyc++) begin
      if ((cyc % 3) == 2) begin
        gen_bit(b);
        cnt++;
        step(1'b0, b, 1'b1, 1'b0, ex("sparse", (cnt >= 36) ? 1 : 0, 0, 0, SM_EXP));
      end else begin
        step(1'b0, 1'($urandom), 1'b0, 1'b0, ex("sparse_idle", (cnt >= 36) ? 1 : 0, 0, 0, 0));
      end
    end

    // Clear coincident with an error: count cleared, pulse still raised
    gen_bit(b);
    step(1'b0, ~b, 1'b1, 1'b1, ex("clr_err", 1, 1, 0, SM_EXP));
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("clr_after", 1, 0, 0, 0));
    gen_bit(b);
    step(1'b0, ~b, 1'b1, 1'b0, ex("err_again", 1, 1, 1, SM_EXP));
    gen_bit(b);
    step(1'b0, b, 1'b1, 1'b0, ex("err_hold", 1, 0, 1, SM_EXP));

    // Drain the scoreboard
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("drain", -1, -1, -1, -1));
    step(1'b0, 1'b0, 1'b0, 1'b0, ex("drain", -1, -1, -1, -1));
    @(negedge clk);
    #1;
    check_val("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive end of the 12-bit LFSR pseudo-random bit stream used by the sequence-detector datapath.
- Takes the serial bit stream one bit per valid strobe and self-synchronises to it. Polynomial: taps 0,3,5,11, shift-left, feedback into bit 0, serial bit = MSB.
- Once synchronised, flywheels the sequence and reports lock, per-bit errors and a saturating error count.

Parameters:
- N, 12, history/LFSR width (fixed polynomial; not generic).
- SEED, 12'hC0D, generator seed value (used only by optional feature).
- LOCK_CNT, 24, consecutive predicted-bit matches needed to declare lock.
- WINDOW, 64, valid-bit window length for loss-of-lock evaluation.
- LOSS_THRESH, 8, errors within one window that force loss of lock.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled only on cycles where this is high.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatching bit while LOCKED.
- err_count  out  CNT_W  errors since reset/clear, saturates at all ones.
- seed_mark  out  1  see Optional Feature; tied 0 when the feature is not compiled.

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) clears history, counters, locked, err_pulse, err_count and seed_mark to 0, and sets state to HUNT. Reset mid-operation behaves identically.
- History register h[11:0] holds the newest bit at h[0]. Expected next bit is exp = h[0]^h[3]^h[5]^h[11].
- Cycles with bit_valid=0: no state, history or counter change; err_pulse=0.
- States:
  - HUNT: each valid bit shifts in (h <= {h[10:0],bit_in}). fill_cnt increments; at 12 valid bits go to VERIFY with match_cnt=0.
  - VERIFY: compare bit_in with exp, then shift in the received bit.
    - Match with h != 0: match_cnt++.
    - Mismatch, or h == 0 (lockup guard): match_cnt <= 0.
    - When the match is the LOCK_CNT-th consecutive one, go to LOCKED. locked rises the cycle after that bit.
    - Mismatches here never touch err_count or err_pulse.
  - LOCKED (flywheel): shift in exp, not bit_in, so a single line error is counted exactly once.
    - Mismatch: err_pulse=1 on the next cycle; err_count++ (saturating); win_err++.
    - win_cnt counts valid bits 0..WINDOW-1. On the bit where win_cnt==WINDOW-1, evaluate, then clear win_cnt and win_err.
    - If win_err including the current bit reaches LOSS_THRESH: go to HUNT (fill_cnt=0, history refilled from bit_in); locked falls the next cycle.
- Lock latency from reset: 12+LOCK_CNT valid bits on a clean stream.
- clear_err together with a counted error: err_count becomes 0 (clear wins); err_pulse is still asserted.
- err_count holds at 2^CNT_W-1 once saturated.

Optional Feature:
- Macro PRBS_SEED_MARK_EN.
- Defined: while LOCKED, seed_mark pulses for one cycle, the cycle after a valid bit whose post-shift history equals SEED. This is the sequence period boundary: every 4095 valid bits on a clean stream.
- Undefined: no comparator logic; seed_mark is constant 0.

Test Plan:
- Reset, then clean generator stream from seed 12'hC0D, bit_valid=1 every cycle -> locked=1 exactly the cycle after the 36th valid bit; err_count=0 after 5000 bits.
- Locked, invert one single bit -> exactly one err_pulse one cycle later; err_count=1; locked stays 1.
- Locked, then force bit_in=0 for 64 bits -> locked drops within the window; err_count >= 8. Resume clean stream -> relock after 36 valid bits.
- Stuck-at-0 input for 200 valid bits after reset -> locked never asserts; err_count=0.
- Clean stream with bit_valid every 3rd cycle -> lock after 36 valid bits (about 108 cycles). Then clear_err coincident with an injected error -> err_count=0 and err_pulse=1.
- With PRBS_SEED_MARK_EN, locked clean stream -> seed_mark pulses spaced exactly 4095 valid bits apart. Reset asserted mid-lock -> all outputs 0 on the next cycle.
